// File: rtl/mdu_pkg.sv
// Shared types, encodings and fn3 decode helpers for the RV32M multi-cycle unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

   // MUL is treated as signed; its low half is identical either way.
   function automatic logic is_signed_a(input logic [2:0] f);
      return !((f == MULHU) || (f == DIVU) || (f == REMU));
   endfunction

   function automatic logic is_signed_b(input logic [2:0] f);
      return (f == MUL) || (f == MULH) || (f == DIV) || (f == REM);
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Decoder/register-file side bundle between the core and the M-extension sequencer.
interface mdu_sequencer_if #(
   parameter int N = 32
) ();
   logic [6:0]   opcode;
   logic [2:0]   fn3;
   logic         fn7_1;
   logic [N-1:0] rs1_data;
   logic [N-1:0] rs2_data;
   logic         stall;
   logic         busy;
   logic [N-1:0] result;
   logic         result_valid;

   modport master (
      output opcode, fn3, fn7_1, rs1_data, rs2_data,
      input  stall, busy, result, result_valid
   );

   modport slave (
      input  opcode, fn3, fn7_1, rs1_data, rs2_data,
      output stall, busy, result, result_valid
   );
endinterface

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring shift-subtract divide
// on magnitudes. hi:lo is the product; for divide lo is the quotient, hi the remainder.
module mdu_iter_core #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         div_mode,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   output logic [N-1:0] hi_next,
   output logic [N-1:0] lo_next
);
   logic [N-1:0] hi;
   logic [N-1:0] lo;
   logic [N-1:0] opb;
   logic [N:0]   sum;
   logic [N:0]   shifted;
   logic [N-1:0] diff;
   logic         ge;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(N+1){1'b0}});
      shifted = {hi, lo[N-1]};
      diff    = shifted[N-1:0] - opb;
      ge      = shifted >= {1'b0, opb};
      if (div_mode) begin
         // Partial remainder stays below the divisor, so N bits always suffice.
         hi_next = ge ? diff : shifted[N-1:0];
         lo_next = {lo[N-2:0], ge};
      end else begin
         hi_next = sum[N:1];
         lo_next = {sum[0], lo[N-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi  <= '0;
         lo  <= '0;
         opb <= '0;
      end else if (load) begin
         hi  <= '0;
         lo  <= a_in;
         opb <= b_in;
      end else if (step) begin
         hi  <= hi_next;
         lo  <= lo_next;
      end
   end
endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: stalls the core, runs mdu_iter_core for N steps and
// applies sign fix-up. Define MDU_EARLY_OUT_EN to skip CALC for trivial operands.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int N     = 32,
   parameter int CNT_W = $clog2(N) + 1
) (
   input  logic           clk,
   input  logic           rst,
   mdu_sequencer_if.slave bus
);
   localparam logic [1:0] IDLE = S_IDLE;
   localparam logic [1:0] CALC = S_CALC;
   localparam logic [1:0] DONE = S_DONE;

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [2:0]       op;
   logic             neg_p;
   logic             neg_r;
   logic [N-1:0]     result_q;
   logic             mop;
   logic             sa;
   logic             sb;
   logic [N-1:0]     mag_a;
   logic [N-1:0]     mag_b;
   logic             div_zero;
   logic             early;
   logic             load;
   logic             last;
   logic [N-1:0]     hi_next;
   logic [N-1:0]     lo_next;
   logic [N-1:0]     quick_res;

   function automatic logic [N-1:0] fix_result(input logic [2:0] f, input logic np,
                                               input logic nr, input logic [N-1:0] h,
                                               input logic [N-1:0] l);
      logic [2*N-1:0] prod;
      prod = np ? -{h, l} : {h, l};
      case (f)
         MUL:                 return prod[N-1:0];
         MULH, MULHSU, MULHU: return prod[2*N-1:N];
         DIV, DIVU:           return np ? -l : l;
         default:             return nr ? -h : h;
      endcase
   endfunction

   assign mop      = (bus.opcode == OPCODE_RTYPE) && bus.fn7_1;
   assign sa       = is_signed_a(bus.fn3) && bus.rs1_data[N-1];
   assign sb       = is_signed_b(bus.fn3) && bus.rs2_data[N-1];
   assign mag_a    = sa ? -bus.rs1_data : bus.rs1_data;
   assign mag_b    = sb ? -bus.rs2_data : bus.rs2_data;
   assign div_zero = is_div(bus.fn3) && (bus.rs2_data == '0);

`ifdef MDU_EARLY_OUT_EN
   assign early = is_div(bus.fn3) ? (mag_a < mag_b)
                                  : ((bus.rs1_data == '0) || (bus.rs2_data == '0));
`else
   assign early = 1'b0;
`endif

   // Results for ops that skip CALC: product 0, or quotient all-ones/0 with remainder rs1.
   always_comb begin
      quick_res = '0;
      if (is_div(bus.fn3)) begin
         if (bus.fn3[1]) quick_res = bus.rs1_data;
         else if (div_zero) quick_res = '1;
      end
   end

   assign load = (state == IDLE) && mop;
   assign last = (count == CNT_W'(N - 1));

   mdu_iter_core #(.N(N)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (state == CALC),
      .div_mode (is_div(op)),
      .a_in     (mag_a),
      .b_in     (mag_b),
      .hi_next  (hi_next),
      .lo_next  (lo_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         op       <= '0;
         neg_p    <= 1'b0;
         neg_r    <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: if (mop) begin
               op    <= bus.fn3;
               neg_p <= sa ^ sb;
               neg_r <= sa;
               count <= '0;
               if (div_zero || early) begin
                  state    <= DONE;
                  result_q <= quick_res;
               end else begin
                  state <= CALC;
               end
            end
            CALC: if (last) begin
               state    <= DONE;
               result_q <= fix_result(op, neg_p, neg_r, hi_next, lo_next);
            end else begin
               count <= count + 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall        = !rst && (((state == IDLE) && mop) || (state == CALC));
   assign bus.busy         = (state != IDLE);
   assign bus.result       = result_q;
   assign bus.result_valid = (state == DONE);
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against an arithmetic RV32M reference model.
module tb_mdu_sequencer;
   localparam int N = 32;
   localparam logic [6:0] RTYPE = 7'b0110011;

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   localparam vec_t VECS [12] = '{
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{3'b100, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA},
      '{3'b110, 32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE},
      '{3'b101, 32'd100,      32'h00000000, 32'hFFFFFFFF},
      '{3'b111, 32'd100,      32'h00000000, 32'd100},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
      '{3'b100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF},
      '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
      '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000}
   };

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   mdu_sequencer_if #(.N(N)) bus ();

   mdu_sequencer #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa64, sb64, sp;
      longint unsigned ua64, ub64, up;
      sa64 = longint'($signed(a));
      sb64 = longint'($signed(b));
      ua64 = {32'd0, a};
      ub64 = {32'd0, b};
      case (f)
         3'b000: begin sp = sa64 * sb64; return sp[31:0]; end
         3'b001: begin sp = sa64 * sb64; return sp[63:32]; end
         3'b010: begin sp = sa64 * longint'(ub64); return sp[63:32]; end
         3'b011: begin up = ua64 * ub64; return up[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            sp = sa64 / sb64;
            return sp[31:0];
         end
         3'b101: begin
            if (b == 0) return 32'hFFFFFFFF;
            up = ua64 / ub64;
            return up[31:0];
         end
         3'b110: begin
            if (b == 0) return a;
            sp = sa64 % sb64;
            return sp[31:0];
         end
         default: begin
            if (b == 0) return a;
            up = ua64 % ub64;
            return up[31:0];
         end
      endcase
   endfunction

   // Cycles with stall high before result_valid: detect cycle plus N iterations, or
   // just the detect cycle when the operation skips iteration.
   function automatic int ref_stall_cycles(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] ma, mb;
      ma = (!f[0] && a[31]) ? -a : a;
      mb = (!f[0] && b[31]) ? -b : b;
      if (f[2] && b == 0) return 1;
`ifdef MDU_EARLY_OUT_EN
      if (!f[2] && (a == 0 || b == 0)) return 1;
      if (f[2] && ma < mb) return 1;
`else
      if (ma == mb && ma == 32'hDEAD_BEEF && mb != ma) return 0;
`endif
      return N + 1;
   endfunction

   task automatic drive_add();
      bus.opcode = RTYPE;
      bus.fn7_1  = 1'b0;
      bus.fn3    = 3'b000;
   endtask

   // Issues one M-op just after a rising edge and follows it until result_valid.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int n_stall, output int vcycle,
                        output logic stall_at_valid);
      n_stall        = 0;
      vcycle         = 0;
      res            = 'x;
      stall_at_valid = 1'bx;
      bus.opcode     = RTYPE;
      bus.fn7_1      = 1'b1;
      bus.fn3        = f;
      bus.rs1_data   = a;
      bus.rs2_data   = b;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (bus.result_valid) begin
            vcycle         = c;
            res            = bus.result;
            stall_at_valid = bus.stall;
            drive_add();
         end else if (bus.stall) begin
            n_stall++;
         end
         @(posedge clk);
         #1;
         if (vcycle != 0) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_add();
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.result !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
      n_checks++; if (bus.result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_mul_latency();
      logic [31:0] res;
      int          ns, vc;
      logic        sv;
      do_op(3'b000, 32'd7, 32'hFFFFFFFD, res, ns, vc, sv);
      n_checks++; if (res !== 32'hFFFFFFEB) begin n_errors++; $display("FAIL mul_result: got %h expected FFFFFFEB", res); end
      n_checks++; if (ns != 33) begin n_errors++; $display("FAIL mul_stall_cycles: got %0d expected 33", ns); end
      n_checks++; if (vc != 34) begin n_errors++; $display("FAIL mul_valid_cycle: got %0d expected 34", vc); end
      n_checks++; if (sv !== 1'b0) begin n_errors++; $display("FAIL mul_stall_at_valid: got %b expected 0", sv); end
      @(negedge clk);
      n_checks++; if (bus.result !== 32'hFFFFFFEB) begin n_errors++; $display("FAIL mul_result_hold: got %h expected FFFFFFEB", bus.result); end
      n_checks++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_errors++; $display("FAIL mul_after_done: valid=%b busy=%b expected 0 0", bus.result_valid, bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [31:0] res;
      int          ns, vc, exp_ns;
      logic        sv;
      for (int i = 0; i < 12; i++) begin
         exp_ns = ref_stall_cycles(VECS[i].f, VECS[i].a, VECS[i].b);
         do_op(VECS[i].f, VECS[i].a, VECS[i].b, res, ns, vc, sv);
         n_checks++; if (res !== VECS[i].exp) begin
            n_errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, VECS[i].exp);
         end
         n_checks++; if (vc != exp_ns + 1 || ns != exp_ns) begin
            n_errors++; $display("FAIL directed_latency[%0d]: valid at %0d stall %0d expected %0d %0d", i, vc, ns, exp_ns + 1, exp_ns);
         end
         n_checks++; if (sv !== 1'b0) begin
            n_errors++; $display("FAIL directed_stall_at_valid[%0d]: got %b expected 0", i, sv);
         end
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] a, b, res, exp;
      logic [2:0]  f;
      int          ns, vc, exp_ns;
      logic        sv;
      for (int i = 0; i < 40; i++) begin
         f      = 3'($urandom_range(0, 7));
         a      = pick_operand();
         b      = pick_operand();
         exp    = ref_result(f, a, b);
         exp_ns = ref_stall_cycles(f, a, b);
         do_op(f, a, b, res, ns, vc, sv);
         n_checks++; if (res !== exp) begin
            n_errors++; $display("FAIL random_result[%0d]: fn3=%0d a=%h b=%h got %h expected %h", i, f, a, b, res, exp);
         end
         n_checks++; if (vc != exp_ns + 1) begin
            n_errors++; $display("FAIL random_latency[%0d]: fn3=%0d got %0d expected %0d", i, f, vc, exp_ns + 1);
         end
      end
   endtask

   task automatic test_non_m();
      drive_add();
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL non_m_add[%0d]: stall=%b busy=%b expected 0 0", i, bus.stall, bus.busy);
         end
         @(posedge clk);
         #1;
      end
      bus.opcode = 7'b0010011;
      bus.fn7_1  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL non_m_opcode[%0d]: stall=%b busy=%b expected 0 0", i, bus.stall, bus.busy);
         end
         @(posedge clk);
         #1;
      end
      drive_add();
   endtask

   task automatic test_reset_mid();
      bit seen_valid, seen_stall;
      bus.opcode   = RTYPE;
      bus.fn7_1    = 1'b1;
      bus.fn3      = 3'b100;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd7;
      @(negedge clk);
      n_checks++; if (bus.stall !== 1'b1) begin n_errors++; $display("FAIL mid_detect_stall: got %b expected 1", bus.stall); end
      repeat (11) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
      rst = 1'b1;
      drive_add();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.stall !== 1'b0) begin n_errors++; $display("FAIL mid_reset_stall: got %b expected 0", bus.stall); end
      n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mid_reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.result !== 32'h0) begin n_errors++; $display("FAIL mid_reset_result: got %h expected 00000000", bus.result); end
      n_checks++; if (bus.result_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.result_valid); end
      seen_valid = 0;
      seen_stall = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.result_valid) seen_valid = 1;
         if (bus.stall) seen_stall = 1;
      end
      n_checks++; if (seen_valid) begin n_errors++; $display("FAIL mid_no_valid: got 1 expected 0"); end
      n_checks++; if (seen_stall) begin n_errors++; $display("FAIL mid_add_stall: got 1 expected 0"); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_directed();
      test_random();
      test_non_m();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle controller for RV32M instructions in the single-cycle core.
- Detects M-type instructions (opcode 0110011, fn7_1=1) from decoder outputs and freezes the PC/register write with `stall`.
- Sequences an iterative shift-add multiplier and restoring divider, then presents a one-cycle `result_valid` so the core writes rd and advances.

Parameters:
- N, 32, operand/result width (XLEN)
- CNT_W, $clog2(N)+1, iteration counter width

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- opcode  input  7  decoded opcode
- fn3  input  3  decoded funct3 (M op select)
- fn7_1  input  1  decoded funct7[0] (M-extension flag)
- rs1_data  input  N  register-file read data for rs1
- rs2_data  input  N  register-file read data for rs2
- stall  output  1  hold PC and suppress rd write
- busy  output  1  FSM not IDLE
- result  output  N  M-op result for rd writeback mux
- result_valid  output  1  result is valid this cycle; core writes rd and advances PC

Behaviour:
- Clock and reset:
  - Single clock `clk`; `rst` is synchronous, active-high.
  - On reset: state=IDLE, counter=0, all operand/accumulator registers 0.
  - Reset values of outputs: stall=0, busy=0, result=0, result_valid=0.
  - Reset mid-operation aborts the operation; no result_valid follows.
- M-instruction detection: `mop = (opcode==7'b0110011) && fn7_1`.
- fn3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, CALC, DONE:
  - IDLE: `stall` = combinational `mop`. When mop=1, latch operands and fn3, take magnitudes for signed ops, record result sign, counter=0.
    - Divisor==0 → DONE next cycle.
    - Otherwise → CALC.
  - CALC: stall=1, busy=1. One iteration per cycle, counter increments.
    - Multiply: shift-add on a 2N-bit accumulator.
    - Divide: restoring shift-subtract giving quotient and remainder.
    - After N iterations (counter==N-1 processed) → DONE.
  - DONE: stall=0, result_valid=1 for exactly one cycle. result is registered and holds until the next DONE. Next state is IDLE.
- The instruction word is unchanged while stalled. The cycle after DONE presents the next PC's instruction, so the same instruction is never restarted.
- Latency: detect cycle + N CALC + 1 DONE = N+2 cycles (34 for N=32). Divide-by-zero takes 2 cycles.
- Result selection:
  - MUL: low N bits of the product.
  - MULH/MULHSU/MULHU: high N bits.
    - Signed product is negated (2N-bit two's complement) when operand signs differ.
    - MULHSU treats rs2 as unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Boundary cases:
  - Divide by zero: quotient = all ones; remainder = rs1_data.
  - Signed overflow (DIV/REM, rs1=-2^(N-1), rs2=-1): quotient=-2^(N-1), remainder=0. Falls out of the magnitude algorithm; must not be special-cased incorrectly.
  - Non-M opcode in IDLE: no action, stall=0.
  - R-type with fn7_1=0 never triggers.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined — IDLE goes straight to DONE (2-cycle latency) when:
  - a multiply has either operand ==0 (result 0); or
  - an unsigned or magnitude divide has |rs1|<|rs2| (quotient 0, remainder=rs1_data).
- Not defined — only divide-by-zero skips CALC; every other op takes N+2 cycles.

Decomposition:
- Package mdu_pkg:
  - state enum {IDLE, CALC, DONE}
  - localparam OPCODE_RTYPE = 7'b0110011
  - fn3 localparams MUL..REMU
  - helper functions is_div(fn3), is_signed_a(fn3), is_signed_b(fn3)
- Sub-module mdu_iter_core: one-step shift-add/shift-subtract datapath with accumulator, quotient and remainder registers. Controlled by the sequencer with load/step/mode signals; no FSM of its own.
- mdu_sequencer owns the FSM, counter, sign fix-up and result register.

Test Plan:
- MUL rs1=7, rs2=-3 → stall high 33 cycles, result_valid in cycle 34 with result=0xFFFFFFEB, stall low that cycle.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result=0xFFFFFFFE; MULH same operands → result=0x00000000.
- DIV rs1=-20, rs2=3 → result=0xFFFFFFFA (-6); REM same operands → 0xFFFFFFFE (-2).
- DIVU rs1=100, rs2=0 → result_valid after 2 cycles, result=0xFFFFFFFF; REMU → result=100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → result=0x80000000; REM → 0.
- Assert rst at CALC counter=10 → next cycle stall=0, busy=0, result=0, no result_valid. ADD (fn7_1=0) afterwards → stall stays 0.
